// File: rtl/iter_ctrl_pkg.sv
// Shared types and defaults for the iterative datapath controller.
package iter_ctrl_pkg;

  localparam int CNT_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    CALC = 2'b10,
    DONE = 2'b11
  } state_t;

endpackage

// File: rtl/iter_counter.sv
// Iteration counter: latches the job's iteration count, steps the 0-based index
// and flags when the index reaches the final iteration.
module iter_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             latch_en,
  input  logic [CNT_W-1:0] n_in,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] iter_idx,
  output logic [CNT_W-1:0] n_lat,
  output logic             tc
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      iter_idx <= '0;
      n_lat    <= '0;
    end else begin
      if (latch_en) n_lat <= n_in;
      if (clear)       iter_idx <= '0;
      else if (enable) iter_idx <= iter_idx + CNT_W'(1);
    end
  end

  // Only meaningful while iterating; n_lat is nonzero whenever CALC is entered.
  assign tc = (iter_idx == n_lat - CNT_W'(1));

endmodule

// File: rtl/iter_ctrl.sv
// Job controller for multi-cycle iterative datapaths: accept, load, N calc
// iterations, then hold the result until consumed. Optional abort input is
// enabled by defining ITER_CTRL_ABORT_EN.
module iter_ctrl
  import iter_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  // Handshakes: a transfer happens on an edge where valid and ready are both 1;
  // valid must not depend on ready, and the offered job/result is held until then.
  input  logic             input_valid,
  output logic             input_ready,
  input  logic [CNT_W-1:0] n_iter,
  output logic             load,
  output logic             clr_res,
  output logic             load_res,
  output logic             cnt_en,
  output logic [CNT_W-1:0] iter_idx,
  output logic             last,
  output logic             busy,
  output logic             output_valid,
  input  logic             output_ready,
`ifdef ITER_CTRL_ABORT_EN
  input  logic             abort,
`endif
  output state_t           dbg_state
);

  state_t           state_q, state_d;
  logic             abort_i;
  logic             accept;
  logic             tc;
  logic [CNT_W-1:0] n_lat;

`ifdef ITER_CTRL_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  assign input_ready = reset && (state_q == IDLE) && !abort_i;
  assign accept      = input_valid && input_ready;
  assign dbg_state   = state_q;

  iter_counter #(.CNT_W(CNT_W)) u_counter (
    .clock    (clock),
    .reset    (reset),
    .latch_en (accept),
    .n_in     (n_iter),
    .clear    (state_q == LOAD),
    .enable   ((state_q == CALC) && !tc),
    .iter_idx (iter_idx),
    .n_lat    (n_lat),
    .tc       (tc)
  );

  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = IDLE;
    load         = 1'b0;
    clr_res      = 1'b0;
    load_res     = 1'b0;
    last         = 1'b0;
    busy         = 1'b0;
    output_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        clr_res = 1'b1;
        state_d = accept ? LOAD : IDLE;
      end
      LOAD: begin
        load = 1'b1;
        busy = 1'b1;
        if (abort_i)             state_d = IDLE;
        else if (n_lat == '0)    state_d = DONE;
        else                     state_d = CALC;
      end
      CALC: begin
        load_res = 1'b1;
        busy     = 1'b1;
        last     = tc;
        if (abort_i)   state_d = IDLE;
        else if (tc)   state_d = DONE;
        else           state_d = CALC;
      end
      DONE: begin
        output_valid = 1'b1;
        busy         = 1'b1;
        state_d      = (abort_i || output_ready) ? IDLE : DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cnt_en = load_res;

endmodule
